// File: rtl/sonic_st_timing_adapter_rl_pkg.sv
// Shared constants and helpers for the Avalon-ST ready-latency timing adapter.
package sonic_st_adapter_pkg;

    localparam int READY_LATENCY_MIN = 0;
    localparam int READY_LATENCY_MAX = 4;

    // Bits needed to hold an entry count of 0..depth inclusive.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Increment a pointer modulo depth; works for non-power-of-two depths.
    function automatic int ptr_wrap(input int ptr, input int depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sonic_st_timing_adapter_rl_if.sv
// Upstream/downstream streaming bundle plus fill/status for the timing adapter.
interface sonic_st_timing_adapter_rl_if
    import sonic_st_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 8
);
    localparam int unsigned FILL_W = fill_width(DEPTH);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [FILL_W-1:0]     fill_level;
    logic                  overflow;
    logic                  protocol_err;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, fill_level, overflow, protocol_err
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, fill_level, overflow, protocol_err
    );

endinterface

// File: rtl/sonic_st_adapter_fifo.sv
// Show-ahead circular buffer: head is always the oldest entry, count tracks occupancy.
module sonic_st_adapter_fifo
    import sonic_st_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         head,
    output logic [fill_width(DEPTH)-1:0]  count
);
    localparam int unsigned FILL_W = fill_width(DEPTH);
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    // A push at full is only accepted when a pop frees the slot in the same cycle.
    assign full    = (count == FILL_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(ptr_wrap(int'(wr_ptr), DEPTH));
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(ptr_wrap(int'(rd_ptr), DEPTH));
            end
            if (do_push && !do_pop) begin
                count <= count + FILL_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sonic_st_timing_adapter_rl.sv
// Avalon-ST timing adapter bridging arbitrary upstream/downstream ready latencies
// through a show-ahead buffer, with sticky overflow and protocol-error status.
module sonic_st_timing_adapter_rl
    import sonic_st_adapter_pkg::*;
#(
    parameter int DATA_WIDTH        = 72,
    parameter int DEPTH             = 8,
    parameter int IN_READY_LATENCY  = 0,
    parameter int OUT_READY_LATENCY = 0
) (
    input logic                         clk,
    input logic                         reset_n,
    sonic_st_timing_adapter_rl_if.slave st
);
    localparam int unsigned FILL_W = fill_width(DEPTH);

    if (DEPTH < IN_READY_LATENCY + 2 ||
        IN_READY_LATENCY  < READY_LATENCY_MIN || IN_READY_LATENCY  > READY_LATENCY_MAX ||
        OUT_READY_LATENCY < READY_LATENCY_MIN || OUT_READY_LATENCY > READY_LATENCY_MAX) begin : g_bad_param
        $error("sonic_st_timing_adapter_rl: illegal DEPTH or ready latency");
    end

    logic [FILL_W-1:0]     fill_level;
    logic [DATA_WIDTH-1:0] head;
    int                    outstanding;
    logic                  in_ready;
    logic                  grant;
    logic                  out_ok;
    logic                  out_valid;
    logic                  pop;
    logic                  full;
    logic                  overflow_c;
    logic                  overflow_q;
    logic                  protocol_err_q;

    // Grants still in flight reserve space, so pops are never credited early.
    assign in_ready = reset_n && ((int'(fill_level) + outstanding) < DEPTH);

    if (IN_READY_LATENCY > 0) begin : g_in_hist
        logic [IN_READY_LATENCY-1:0] in_hist;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                in_hist <= '0;
            end else begin
                in_hist <= (in_hist << 1) | IN_READY_LATENCY'(in_ready);
            end
        end

        assign grant       = in_hist[IN_READY_LATENCY-1];
        assign outstanding = $countones(in_hist);
    end else begin : g_in_direct
        assign grant       = in_ready;
        assign outstanding = 0;
    end

    // With a downstream latency, every presented beat is already granted and pops.
    if (OUT_READY_LATENCY > 0) begin : g_out_hist
        logic [OUT_READY_LATENCY-1:0] out_hist;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_hist <= '0;
            end else begin
                out_hist <= (out_hist << 1) | OUT_READY_LATENCY'(st.out_ready);
            end
        end

        assign out_ok = out_hist[OUT_READY_LATENCY-1];
        assign pop    = out_valid;
    end else begin : g_out_direct
        assign out_ok = 1'b1;
        assign pop    = out_valid && st.out_ready;
    end

    assign out_valid  = (fill_level != '0) && out_ok;
    assign full       = (fill_level == FILL_W'(DEPTH));
    assign overflow_c = st.in_valid && full && !pop;

    sonic_st_adapter_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (st.in_valid),
        .pop     (pop),
        .wdata   (st.in_data),
        .head    (head),
        .count   (fill_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            if (overflow_c) begin
                overflow_q <= 1'b1;
            end
            if (st.in_valid && !grant) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    assign st.in_ready     = in_ready;
    assign st.out_valid    = out_valid;
    assign st.out_data     = head;
    assign st.fill_level   = fill_level;
    assign st.overflow     = overflow_q;
    assign st.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_sonic_st_timing_adapter_rl.sv
// Randomised and directed bench for the timing adapter against a queue-based reference model.
module tb_sonic_st_timing_adapter_rl;
    localparam int DW      = 72;
    localparam int A_DEPTH = 8;
    localparam int A_IRL   = 2;
    localparam int A_ORL   = 1;
    localparam int B_DEPTH = 4;
    localparam int B_IRL   = 0;
    localparam int B_ORL   = 0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sonic_st_timing_adapter_rl_if #(.DATA_WIDTH(DW), .DEPTH(A_DEPTH)) a_if ();
    sonic_st_timing_adapter_rl_if #(.DATA_WIDTH(DW), .DEPTH(B_DEPTH)) b_if ();

    sonic_st_timing_adapter_rl #(
        .DATA_WIDTH(DW), .DEPTH(A_DEPTH), .IN_READY_LATENCY(A_IRL), .OUT_READY_LATENCY(A_ORL)
    ) dut_a (.clk(clk), .reset_n(reset_n), .st(a_if));

    sonic_st_timing_adapter_rl #(
        .DATA_WIDTH(DW), .DEPTH(B_DEPTH), .IN_READY_LATENCY(B_IRL), .OUT_READY_LATENCY(B_ORL)
    ) dut_b (.clk(clk), .reset_n(reset_n), .st(b_if));

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: beats held in a queue, grant histories as plain bit arrays.
    logic [DW-1:0] mq [2][$];
    bit            ghist [2][5];
    bit            ohist [2][5];
    bit            m_ovf [2];
    bit            m_perr [2];

    function automatic int depth_of(input int i); return (i == 0) ? A_DEPTH : B_DEPTH; endfunction
    function automatic int irl_of(input int i);   return (i == 0) ? A_IRL : B_IRL;     endfunction
    function automatic int orl_of(input int i);   return (i == 0) ? A_ORL : B_ORL;     endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_ovf[i]  = 1'b0;
            m_perr[i] = 1'b0;
            for (int k = 0; k < 5; k++) begin
                ghist[i][k] = 1'b0;
                ohist[i][k] = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int i, input logic iv, input logic [DW-1:0] id, input logic ordy,
                              input logic irdy, input logic ov, input logic [DW-1:0] od,
                              input int fill, input logic ovf, input logic perr);
        int    sz;
        int    outst;
        bit    exp_ir;
        bit    exp_ov;
        bit    oh;
        bit    granted;
        bit    pop;
        string p;
        p     = (i == 0) ? "a" : "b";
        sz    = mq[i].size();
        outst = 0;
        for (int k = 0; k < irl_of(i); k++) outst += int'(ghist[i][k]);
        exp_ir = (sz + outst) < depth_of(i);
        oh     = (orl_of(i) == 0) ? 1'b1 : ohist[i][orl_of(i) - 1];
        exp_ov = (sz > 0) && oh;
        check({p, ".in_ready"},     DW'(irdy), DW'(exp_ir));
        check({p, ".out_valid"},    DW'(ov),   DW'(exp_ov));
        check({p, ".fill_level"},   DW'(fill), DW'(sz));
        check({p, ".overflow"},     DW'(ovf),  DW'(m_ovf[i]));
        check({p, ".protocol_err"}, DW'(perr), DW'(m_perr[i]));
        if (exp_ov) check({p, ".out_data"}, od, mq[i][0]);
        granted = (irl_of(i) == 0) ? exp_ir : ghist[i][irl_of(i) - 1];
        pop     = exp_ov && (orl_of(i) != 0 || ordy);
        if (iv && !granted) m_perr[i] = 1'b1;
        if (pop) void'(mq[i].pop_front());
        if (iv) begin
            if (sz < depth_of(i) || pop) mq[i].push_back(id);
            else                         m_ovf[i] = 1'b1;
        end
        for (int k = 4; k > 0; k--) begin
            ghist[i][k] = ghist[i][k-1];
            ohist[i][k] = ohist[i][k-1];
        end
        ghist[i][0] = exp_ir;
        ohist[i][0] = ordy;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                model_reset();
            end else begin
                model_step(0, a_if.in_valid, a_if.in_data, a_if.out_ready, a_if.in_ready, a_if.out_valid,
                           a_if.out_data, int'(a_if.fill_level), a_if.overflow, a_if.protocol_err);
                model_step(1, b_if.in_valid, b_if.in_data, b_if.out_ready, b_if.in_ready, b_if.out_valid,
                           b_if.out_data, int'(b_if.fill_level), b_if.overflow, b_if.protocol_err);
            end
        end
    end

    // Stimulus-side record of dut_a in_ready, used only to decide when a beat is legal.
    bit a_seen [5];

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int k = 4; k > 0; k--) a_seen[k] = a_seen[k-1];
        a_seen[0] = a_if.in_ready;
    endtask

    function automatic logic a_grant(); return a_seen[A_IRL]; endfunction

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic idle_inputs();
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; a_if.in_data = '0;
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b0; b_if.in_data = '0;
    endtask

    initial begin
        logic prev;
        int   pushed;
        idle_inputs();
        for (int k = 0; k < 5; k++) a_seen[k] = 1'b0;
        #1;
        check("rst.a_in_ready_low", DW'(a_if.in_ready), DW'(0));
        repeat (3) cyc();
        check("rst.a_fill",     DW'(a_if.fill_level), DW'(0));
        check("rst.b_out_valid", DW'(b_if.out_valid), DW'(0));
        check("rst.b_overflow", DW'(b_if.overflow),   DW'(0));
        reset_n = 1'b1;
        #1;
        check("rel.a_in_ready", DW'(a_if.in_ready), DW'(1));
        check("rel.b_in_ready", DW'(b_if.in_ready), DW'(1));

        // Pass-through on the latency-0 instance.
        b_if.out_ready = 1'b1;
        for (int v = 1; v <= 32; v++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = DW'(v);
            cyc();
            check("b.pt_fill_le1", DW'(b_if.fill_level <= 1), DW'(1));
            check("b.pt_valid",    DW'(b_if.out_valid),       DW'(1));
            check("b.pt_head",     b_if.out_data,             DW'(v));
        end
        b_if.in_valid = 1'b0;
        cyc();
        check("b.pt_empty", DW'(b_if.fill_level), DW'(0));

        // Upstream latency 2: send exactly on each grant with the output stalled.
        a_if.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a_if.in_valid = a_grant();
            a_if.in_data  = rnd_data();
            cyc();
        end
        a_if.in_valid = 1'b0;
        check("a.lat_fill",     DW'(a_if.fill_level),   DW'(8));
        check("a.lat_in_ready", DW'(a_if.in_ready),     DW'(0));
        check("a.lat_overflow", DW'(a_if.overflow),     DW'(0));
        check("a.lat_perr",     DW'(a_if.protocol_err), DW'(0));

        // Downstream latency 1: drain to 4, then toggle out_ready.
        a_if.out_ready = 1'b1;
        repeat (4) cyc();
        a_if.out_ready = 1'b0;
        repeat (2) cyc();
        check("a.drain_to4", DW'(a_if.fill_level), DW'(4));
        prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_if.out_ready = (k % 2 == 0);
            check("a.ov_follows_ready", DW'(a_if.out_valid), DW'(prev));
            prev = a_if.out_ready;
            cyc();
        end
        a_if.out_ready = 1'b0;
        check("a.toggle_drained2", DW'(a_if.fill_level), DW'(2));

        // Full buffer with simultaneous push and pop.
        b_if.out_ready = 1'b0;
        for (int v = 'h101; v <= 'h104; v++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = DW'(v);
            cyc();
        end
        check("b.full_fill", DW'(b_if.fill_level), DW'(4));
        b_if.in_data   = DW'('h105);
        b_if.out_ready = 1'b1;
        cyc();
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b0;
        check("b.pp_fill",     DW'(b_if.fill_level),   DW'(4));
        check("b.pp_overflow", DW'(b_if.overflow),     DW'(0));
        check("b.pp_head",     b_if.out_data,          DW'('h102));
        check("b.pp_perr",     DW'(b_if.protocol_err), DW'(1));
        b_if.out_ready = 1'b1;
        repeat (5) cyc();
        b_if.out_ready = 1'b0;
        check("b.drained", DW'(b_if.fill_level), DW'(0));

        // Overflow: six beats into a depth-4 buffer, ignoring in_ready.
        for (int v = 'h201; v <= 'h206; v++) begin
            b_if.in_valid = 1'b1;
            b_if.in_data  = DW'(v);
            cyc();
        end
        b_if.in_valid = 1'b0;
        check("b.ovf_fill", DW'(b_if.fill_level),   DW'(4));
        check("b.ovf_head", b_if.out_data,          DW'('h201));
        check("b.ovf_flag", DW'(b_if.overflow),     DW'(1));
        check("b.ovf_perr", DW'(b_if.protocol_err), DW'(1));
        b_if.out_ready = 1'b1;
        repeat (2) cyc();
        check("b.ovf_sticky", DW'(b_if.overflow), DW'(1));
        check("b.ovf_head3",  b_if.out_data,      DW'('h203));
        repeat (3) cyc();

        // Refill dut_a to 5 beats and reset while it is presenting data.
        pushed = 0;
        for (int k = 0; k < 12 && pushed < 3; k++) begin
            a_if.in_valid = a_grant();
            a_if.in_data  = rnd_data();
            if (a_if.in_valid) pushed++;
            cyc();
        end
        a_if.in_valid = 1'b0;
        cyc();
        check("a.pre_rst_fill", DW'(a_if.fill_level), DW'(5));
        a_if.out_ready = 1'b1;
        cyc();
        check("a.pre_rst_valid", DW'(a_if.out_valid), DW'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst.a_out_valid", DW'(a_if.out_valid),    DW'(0));
        check("mid_rst.a_in_ready",  DW'(a_if.in_ready),     DW'(0));
        check("mid_rst.a_fill",      DW'(a_if.fill_level),   DW'(0));
        check("mid_rst.b_overflow",  DW'(b_if.overflow),     DW'(0));
        check("mid_rst.b_perr",      DW'(b_if.protocol_err), DW'(0));
        idle_inputs();
        repeat (3) cyc();
        reset_n = 1'b1;
        #1;
        b_if.in_valid = 1'b1;
        b_if.in_data  = DW'('h3AB);
        cyc();
        b_if.in_valid = 1'b0;
        check("post_rst.b_valid", DW'(b_if.out_valid), DW'(1));
        check("post_rst.b_head",  b_if.out_data,       DW'('h3AB));
        check("post_rst.b_fill",  DW'(b_if.fill_level), DW'(1));

        // Randomised traffic; dut_a stays protocol-clean, dut_b is driven freely.
        for (int k = 0; k < 600; k++) begin
            a_if.in_valid  = a_grant() && ($urandom_range(3) != 0);
            a_if.in_data   = rnd_data();
            a_if.out_ready = 1'($urandom_range(1));
            b_if.in_valid  = 1'($urandom_range(1));
            b_if.in_data   = rnd_data();
            b_if.out_ready = ($urandom_range(2) != 0);
            cyc();
        end
        idle_inputs();
        cyc();
        check("end.a_perr", DW'(a_if.protocol_err), DW'(0));
        check("end.a_ovf",  DW'(a_if.overflow),     DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
